fish_mover: RTL and testbench

//  Generates the fishX/fishY sprite position consumed by the fish renderer. Swims the

---
 rtl/fish_pkg.sv | 20 ++
 rtl/fish_mover_if.sv | 25 ++
 rtl/fish_lfsr.sv | 20 ++
 rtl/fish_mover.sv | 148 ++++++++++++++
 tb/tb_fish_mover.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fish_pkg.sv
// Constants and types shared by the fish mover and the fish renderer.
// Pure declarations, no logic: no latency and no backpressure.
package fish_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWIM,
    CAUGHT,
    RESPAWN
  } fish_state_t;

  localparam int H_RES         = 640;
  localparam int V_RES         = 480;
  localparam int SPRITE_W      = 90;
  localparam int SPRITE_HALF_H = 30;

  localparam int POS_W = 12;
  typedef logic signed [POS_W-1:0] pos_t;

endpackage

// File: rtl/fish_mover_if.sv
// Frame-timing/game-logic inputs and sprite-position outputs of the fish mover.
// Plain signal bundle with no handshake: outputs are sampled by the renderer every frame, so there is no backpressure.
interface fish_mover_if;
  import fish_pkg::*;

  logic frame_tick;
  logic enable;
  logic hit;
  pos_t fishX;
  pos_t fishY;
  logic fish_visible;
  logic caught_pulse;
  logic escape_pulse;

  modport master (
    input  frame_tick, enable, hit,
    output fishX, fishY, fish_visible, caught_pulse, escape_pulse
  );

  modport slave (
    output frame_tick, enable, hit,
    input  fishX, fishY, fish_visible, caught_pulse, escape_pulse
  );

endinterface

// File: rtl/fish_lfsr.sv
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1) used to pick the respawn depth.
// Advances one step per enabled clock; the output is the state register itself, with no backpressure.
module fish_lfsr #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[8:0], q[9] ^ q[6]};
    end
  end

endmodule

// File: rtl/fish_mover.sv
// Moves the fish sprite left once per frame with a vertical bob, and handles catch, escape and respawn.
// All outputs are registered; position updates on frame_tick, except the respawn load one cycle after it. No backpressure.
module fish_mover #(
  parameter int         SPEED_X    = 2,
  parameter int         BOB_AMP    = 8,
  parameter int         Y_MIN      = 60,
  parameter int         Y_MAX      = 420,
  parameter int         HIT_FRAMES = 30,
  parameter logic [9:0] LFSR_SEED  = 10'h2A5
) (
  input  logic         clk,
  input  logic         rst_n,
  fish_mover_if.master bus
);
  import fish_pkg::*;

  localparam pos_t       X_START = pos_t'(H_RES + SPRITE_W);
  localparam pos_t       Y_MID   = pos_t'((Y_MIN + Y_MAX) / 2);
  localparam pos_t       BOB_HI  = pos_t'(BOB_AMP);
  localparam pos_t       BOB_LO  = pos_t'(-BOB_AMP);
  localparam logic [9:0] Y_SPAN  = 10'(Y_MAX - Y_MIN + 1);
  localparam logic [7:0] CNT_END = 8'(HIT_FRAMES - 1);

  fish_state_t state;
  pos_t        x;
  pos_t        y;
  pos_t        base_y;
  pos_t        bob;
  logic        bob_up;
  logic        visible;
  logic        caught;
  logic        escaped;
  logic [7:0]  cnt;
  logic [9:0]  lfsr;

  fish_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .q     (lfsr)
  );

  logic unused_lfsr_msb;
  assign unused_lfsr_msb = lfsr[9];

  logic signed [12:0] x_step;
  pos_t               bob_step;
  pos_t               spawn_y;
  logic [9:0]         r_wrap;
  logic [7:0]         cnt_inc;

  // One extra bit on the X step so a fish near the left edge goes negative instead of wrapping.
  always_comb begin
    x_step   = {x[11], x} - 13'(SPEED_X);
    bob_step = bob_up ? (bob + pos_t'(1)) : (bob - pos_t'(1));
    r_wrap   = ({1'b0, lfsr[8:0]} < Y_SPAN) ? {1'b0, lfsr[8:0]}
                                            : ({1'b0, lfsr[8:0]} - Y_SPAN);
    spawn_y  = pos_t'(Y_MIN) + pos_t'({2'b00, r_wrap});
    cnt_inc  = cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= X_START;
      y       <= Y_MID;
      base_y  <= Y_MID;
      bob     <= '0;
      bob_up  <= 1'b1;
      visible <= 1'b0;
      caught  <= 1'b0;
      escaped <= 1'b0;
      cnt     <= '0;
    end else begin
      caught  <= 1'b0;
      escaped <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state   <= SWIM;
            visible <= 1'b1;
          end
        end
        // Losing enable outranks everything; a hit outranks a coincident frame move.
        SWIM: begin
          if (!bus.enable) begin
            state   <= IDLE;
            visible <= 1'b0;
          end else if (bus.hit) begin
            state   <= CAUGHT;
            caught  <= 1'b1;
            cnt     <= '0;
            visible <= 1'b1;
          end else if (bus.frame_tick) begin
            if (x_step[12]) begin
              state   <= RESPAWN;
              escaped <= 1'b1;
              visible <= 1'b0;
            end else begin
              x   <= x_step[11:0];
              bob <= bob_step;
              y   <= base_y + bob_step;
              if (bob_step == BOB_HI) begin
                bob_up <= 1'b0;
              end else if (bob_step == BOB_LO) begin
                bob_up <= 1'b1;
              end
            end
          end
        end
        CAUGHT: begin
          if (!bus.enable) begin
            state   <= IDLE;
            visible <= 1'b0;
          end else if (bus.frame_tick) begin
            if (cnt == CNT_END) begin
              state   <= RESPAWN;
              visible <= 1'b0;
            end else begin
              cnt     <= cnt_inc;
              visible <= ~cnt_inc[2];
            end
          end
        end
        RESPAWN: begin
          x       <= X_START;
          base_y  <= spawn_y;
          y       <= spawn_y;
          bob     <= '0;
          bob_up  <= 1'b1;
          state   <= bus.enable ? SWIM : IDLE;
          visible <= bus.enable;
        end
        default: begin
          state   <= IDLE;
          visible <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fishX        = x;
  assign bus.fishY        = y;
  assign bus.fish_visible = visible;
  assign bus.caught_pulse = caught;
  assign bus.escape_pulse = escaped;

endmodule

// File: tb/tb_fish_mover.sv
// Bench for fish_mover: an abstract lifetime model feeds a per-cycle expected-output queue, and a monitor compares it against the DUT.
module tb_fish_mover;

  localparam int X0    = 730;
  localparam int Y0    = 240;
  localparam int YMIN  = 60;
  localparam int YMAX  = 420;
  localparam int SPAN  = 361;
  localparam int SPEED = 2;
  localparam int HITF  = 30;

  localparam int M_OFF   = 0;
  localparam int M_SWIM  = 1;
  localparam int M_HELD  = 2;
  localparam int M_SPAWN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fish_mover_if bus ();

  fish_mover dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        vis;
    logic        cp;
    logic        ep;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int         m_mode  = M_OFF;
  int         m_moves = 0;
  int         m_base  = Y0;
  int         m_held  = 0;
  logic       m_vis   = 1'b0;
  logic [9:0] m_lfsr  = 10'h2A5;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Vertical offset as a function of frames swum since respawn: triangle of amplitude 8, period 32.
  function automatic int bob_of(input int p);
    int t;
    t = p % 32;
    if (t <= 8) return t;
    if (t <= 24) return 16 - t;
    return t - 32;
  endfunction

  task automatic model_step();
    logic cp;
    logic ep;
    int   r;
    exp_t e;
    cp = 1'b0;
    ep = 1'b0;
    case (m_mode)
      M_OFF: begin
        if (bus.enable) begin m_mode = M_SWIM; m_vis = 1'b1; end
      end
      M_SWIM: begin
        if (!bus.enable) begin
          m_mode = M_OFF; m_vis = 1'b0;
        end else if (bus.hit) begin
          cp = 1'b1; m_held = 0; m_mode = M_HELD;
        end else if (bus.frame_tick) begin
          if (X0 - SPEED * m_moves - SPEED < 0) begin
            ep = 1'b1; m_mode = M_SPAWN; m_vis = 1'b0;
          end else begin
            m_moves++;
          end
        end
      end
      M_HELD: begin
        if (!bus.enable) begin
          m_mode = M_OFF; m_vis = 1'b0;
        end else if (bus.frame_tick) begin
          m_held++;
          if (m_held == HITF) begin
            m_mode = M_SPAWN; m_vis = 1'b0;
          end else begin
            m_vis = ((m_held / 4) % 2) == 0;
          end
        end
      end
      M_SPAWN: begin
        r       = int'(m_lfsr[8:0]);
        m_base  = YMIN + (r % SPAN);
        m_moves = 0;
        m_mode  = bus.enable ? M_SWIM : M_OFF;
        m_vis   = bus.enable;
      end
      default: m_mode = M_OFF;
    endcase
    m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    e.x   = 12'(X0 - SPEED * m_moves);
    e.y   = 12'(m_base + bob_of(m_moves));
    e.vis = m_vis;
    e.cp  = cp;
    e.ep  = ep;
    exp_q.push_back(e);
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_mode = M_OFF; m_moves = 0; m_base = Y0; m_held = 0;
        m_vis = 1'b0; m_lfsr = 10'h2A5;
      end else begin
        model_step();
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.fishX, bus.fishY, bus.fish_visible, bus.caught_pulse, bus.escape_pulse} === e)
          n_pass++;
        else
          $display("FAIL outputs @%0t: got x=%0d y=%0d vis=%0b cp=%0b ep=%0b, expected x=%0d y=%0d vis=%0b cp=%0b ep=%0b",
                   $time, bus.fishX, bus.fishY, bus.fish_visible, bus.caught_pulse, bus.escape_pulse,
                   e.x, e.y, e.vis, e.cp, e.ep);
      end
    end
  end

  task automatic drive(input logic t, input logic h, input logic e);
    bus.frame_tick = t;
    bus.hit        = h;
    bus.enable     = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"},   int'(bus.fishX), X0);
    check({tag, "_y"},   int'(bus.fishY), Y0);
    check({tag, "_vis"}, int'(bus.fish_visible), 0);
    check({tag, "_cp"},  int'(bus.caught_pulse), 0);
    check({tag, "_ep"},  int'(bus.escape_pulse), 0);
  endtask

  initial begin : stimulus
    logic seen;
    logic en;
    int   yv;
    bus.frame_tick = 1'b0;
    bus.hit        = 1'b0;
    bus.enable     = 1'b0;
    rst_n          = 1'b0;
    #12;
    check_reset_values("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Swim ten frames from the spawn point.
    drive(0, 0, 1);
    check("vis_after_enable", int'(bus.fish_visible), 1);
    repeat (10) begin drive(1, 0, 1); drive(0, 0, 1); end
    check("swim10_x", int'(bus.fishX), 710);
    check("swim10_y", int'(bus.fishY), 246);

    // Hit on the same cycle as a frame tick, then the full blink period.
    drive(1, 1, 1);
    check("hit_tick_cp", int'(bus.caught_pulse), 1);
    check("hit_tick_x", int'(bus.fishX), 710);
    check("hit_tick_ep", int'(bus.escape_pulse), 0);
    drive(0, 0, 1);
    check("cp_one_cycle", int'(bus.caught_pulse), 0);
    repeat (29) begin drive(1, 0, 1); drive(0, 0, 1); end
    check("caught_frozen_x", int'(bus.fishX), 710);
    drive(1, 0, 1);
    check("respawn_vis", int'(bus.fish_visible), 0);
    drive(0, 0, 1);
    check("respawn_x", int'(bus.fishX), X0);
    yv = int'(bus.fishY);
    check("respawn_y_range", int'(yv >= YMIN && yv <= YMAX), 1);

    // Swim all the way off the left edge.
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      drive(1, 0, 1);
      if (bus.escape_pulse) seen = 1'b1;
      else drive(0, 0, 1);
    end
    check("escape_seen", int'(seen), 1);
    drive(0, 0, 1);
    check("escape_respawn_x", int'(bus.fishX), X0);
    yv = int'(bus.fishY);
    check("escape_y_range", int'(yv >= YMIN && yv <= YMAX), 1);

    // Pause mid-swim and resume from the same spot.
    repeat (5) begin drive(1, 0, 1); drive(0, 0, 1); end
    drive(1, 0, 0);
    repeat (3) begin drive(1, 0, 0); drive(0, 0, 0); end
    check("paused_vis", int'(bus.fish_visible), 0);
    check("paused_x", int'(bus.fishX), 720);
    drive(0, 0, 1);
    check("resume_vis", int'(bus.fish_visible), 1);
    drive(1, 0, 1);
    check("resume_x", int'(bus.fishX), 718);

    // Asynchronous reset in the middle of a catch.
    drive(0, 1, 1);
    check("catch2_cp", int'(bus.caught_pulse), 1);
    repeat (6) begin drive(1, 0, 1); drive(0, 0, 1); end
    bus.frame_tick = 1'b0;
    bus.hit        = 1'b0;
    bus.enable     = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_values("async_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized play: enable mostly on, frequent frame ticks, rare hits.
    en = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (en) en = ($urandom_range(0, 299) != 0);
      else    en = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1999) == 0, en);
    end
    drive(0, 0, 0);
    drive(0, 0, 0);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
